// File: rtl/proc_pkg.sv
// proc_pkg: shared processor definitions for the front end.
//   - Instruction field bit positions (opcode / rs / rt / immediate)
//   - Opcode constants used by the fetch-side immediate decode
//   - Fetch FSM state encoding (one bit: FETCH / ISSUE)
//   - seu_sign_sel(): selects sign (1) or zero (0) extension for an opcode
package proc_pkg;

  // Instruction field bit positions
  localparam int unsigned OPCODE_MSB = 31;
  localparam int unsigned OPCODE_LSB = 26;
  localparam int unsigned RS_MSB     = 25;
  localparam int unsigned RS_LSB     = 21;
  localparam int unsigned RT_MSB     = 20;
  localparam int unsigned RT_LSB     = 16;
  localparam int unsigned IMM_MSB    = 15;
  localparam int unsigned IMM_LSB    = 0;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned OPCODE_W   = OPCODE_MSB - OPCODE_LSB + 1;
  localparam int unsigned REG_W      = RS_MSB - RS_LSB + 1;
  localparam int unsigned IMM_W      = IMM_MSB - IMM_LSB + 1;

  // Opcode constants
  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OPCODE_W-1:0] OP_BNE   = 6'h05;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OPCODE_W-1:0] OP_SLTI  = 6'h0A;
  localparam logic [OPCODE_W-1:0] OP_ANDI  = 6'h0C;
  localparam logic [OPCODE_W-1:0] OP_ORI   = 6'h0D;
  localparam logic [OPCODE_W-1:0] OP_XORI  = 6'h0E;
  localparam logic [OPCODE_W-1:0] OP_LW    = 6'h23;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'h2B;

  // Fetch FSM states
  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_ISSUE = 1'b1
  } fetch_state_e;

  // Arithmetic, compare, branch-offset and address-offset immediates are
  // signed; logical immediates and everything else are zero-extended.
  function automatic logic seu_sign_sel(input logic [OPCODE_W-1:0] op);
    logic sel;
    sel = 1'b0;
    case (op)
      OP_BEQ, OP_BNE, OP_ADDI, OP_SLTI, OP_LW, OP_SW: sel = 1'b1;
      default:                                         sel = 1'b0;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/imm_decode.sv
// imm_decode: purely combinational field split of an instruction word.
// Ports:
//   instr_i   in  32  instruction word (IR)
//   opcode_o  out 6   instr[31:26]
//   rs_o      out 5   instr[25:21]
//   rt_o      out 5   instr[20:16]
//   inm_o     out 16  instr[15:0], to the sign-extension unit
//   seu_en_o  out 1   1 = sign-extend inm, 0 = zero-extend inm
module imm_decode
  import proc_pkg::*;
(
  input  logic [XLEN-1:0]     instr_i,
  output logic [OPCODE_W-1:0] opcode_o,
  output logic [REG_W-1:0]    rs_o,
  output logic [REG_W-1:0]    rt_o,
  output logic [IMM_W-1:0]    inm_o,
  output logic                seu_en_o
);

  always_comb begin
    opcode_o = instr_i[OPCODE_MSB:OPCODE_LSB];
    rs_o     = instr_i[RS_MSB:RS_LSB];
    rt_o     = instr_i[RT_MSB:RT_LSB];
    inm_o    = instr_i[IMM_MSB:IMM_LSB];
    seu_en_o = seu_sign_sel(instr_i[OPCODE_MSB:OPCODE_LSB]);
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage. Holds the PC, fetches one 32-bit word
// per FETCH/ISSUE pair over a req/ready handshake, latches it into the IR and
// exposes the decoded opcode/register/immediate fields.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   imem_req / imem_addr      fetch request (level) and address (= PC)
//   imem_ready / imem_rdata   request completion and instruction word
//   stall                     downstream cannot consume the IR this cycle
//   branch_taken / _target    one-cycle redirect; highest priority
//   valid, instr, pc_out      IR holds an instruction, its word and address
//   opcode, rs, rt, inm       IR fields
//   seu_en                    sign (1) / zero (0) extension select for inm
module fetch_unit
  import proc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        valid,
  output logic [31:0] instr,
  output logic [31:0] pc_out,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [15:0] inm,
  output logic        seu_en
);

  fetch_state_e state_q;
  logic [31:0]  pc_q;
  logic [31:0]  ir_q;
  logic [31:0]  pc_out_q;

  // PC is always word aligned; the low target bits are dropped.
  logic [1:0]   unused_tgt_lsbs;
  assign unused_tgt_lsbs = branch_target[1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_FETCH;
      pc_q     <= {RESET_PC[31:2], 2'b00};
      ir_q     <= '0;
      pc_out_q <= '0;
    end else if (branch_taken) begin
      // Redirect wins over a completing fetch and over stall: the returned
      // word is dropped and the IR keeps its old contents.
      state_q <= ST_FETCH;
      pc_q    <= {branch_target[31:2], 2'b00};
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (imem_ready) begin
            ir_q     <= imem_rdata;
            pc_out_q <= pc_q;
            pc_q     <= pc_q + 32'd4;
            state_q  <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (!stall) begin
            state_q <= ST_FETCH;
          end
        end
        default: state_q <= ST_FETCH;
      endcase
    end
  end

  // Handshake outputs come straight from the state register, so they only
  // move on clock edges or on the asynchronous reset.
  assign imem_req  = (state_q == ST_FETCH);
  assign valid     = (state_q == ST_ISSUE);
  assign imem_addr = pc_q;
  assign instr     = ir_q;
  assign pc_out    = pc_out_q;

  imm_decode u_imm_decode (
    .instr_i  (ir_q),
    .opcode_o (opcode),
    .rs_o     (rs),
    .rt_o     (rt),
    .inm_o    (inm),
    .seu_en_o (seu_en)
  );

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        valid;
  logic [31:0] instr;
  logic [31:0] pc_out;
  logic [5:0]  opcode;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [15:0] inm;
  logic        seu_en;

  int vectors;
  int miscompares;

  fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rdata    (imem_rdata),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .valid         (valid),
    .instr         (instr),
    .pc_out        (pc_out),
    .opcode        (opcode),
    .rs            (rs),
    .rt            (rt),
    .inm           (inm),
    .seu_en        (seu_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and land 1 ns past the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // SEU output as the downstream unit would form it.
  function automatic logic [31:0] seu_ext(input logic [15:0] imm, input logic sel);
    return {{16{sel & imm[15]}}, imm};
  endfunction

  task automatic test_reset();
    rst = 1'b1; imem_ready = 1'b0; imem_rdata = '0; stall = 1'b0;
    branch_taken = 1'b0; branch_target = '0;
    #2;
    vectors++; if (imem_addr !== 32'h0000_0100) begin miscompares++; $display("FAIL rst_addr got %h want %h", imem_addr, 32'h100); end
    vectors++; if (imem_req !== 1'b1) begin miscompares++; $display("FAIL rst_req got %b want 1", imem_req); end
    vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid got %b want 0", valid); end
    vectors++; if (instr !== 32'h0) begin miscompares++; $display("FAIL rst_instr got %h want 0", instr); end
    vectors++; if (pc_out !== 32'h0) begin miscompares++; $display("FAIL rst_pc_out got %h want 0", pc_out); end
    vectors++; if ({opcode, inm, seu_en} !== 23'h0) begin miscompares++; $display("FAIL rst_fields got %h/%h/%b want 0", opcode, inm, seu_en); end
    @(negedge clk);
    rst = 1'b0; imem_ready = 1'b1; imem_rdata = 32'h2008_FFFF;
    step();
    vectors++; if (valid !== 1'b1) begin miscompares++; $display("FAIL first_valid got %b want 1", valid); end
    vectors++; if (pc_out !== 32'h0000_0100) begin miscompares++; $display("FAIL first_pc_out got %h want 100", pc_out); end
    vectors++; if (inm !== 16'hFFFF) begin miscompares++; $display("FAIL first_inm got %h want ffff", inm); end
    vectors++; if (seu_en !== 1'b1) begin miscompares++; $display("FAIL first_seu got %b want 1", seu_en); end
    vectors++; if (opcode !== 6'h08) begin miscompares++; $display("FAIL first_opcode got %h want 08", opcode); end
    vectors++; if (rt !== 5'd8 || rs !== 5'd0) begin miscompares++; $display("FAIL first_regs got rs=%0d rt=%0d want rs=0 rt=8", rs, rt); end
    vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL first_req got %b want 0", imem_req); end
    imem_ready = 1'b0;
    step();
    vectors++; if (imem_addr !== 32'h0000_0104 || imem_req !== 1'b1) begin miscompares++; $display("FAIL next_fetch got %h/%b want 104/1", imem_addr, imem_req); end
  endtask

  typedef struct {
    logic [31:0] word;
    logic [5:0]  op;
    logic        sel;
    logic [31:0] ext;
  } dec_vec_t;

  task automatic test_decode();
    dec_vec_t tbl [5];
    logic [31:0] exp_pc;
    tbl[0] = '{32'h3408_000F, 6'h0D, 1'b0, 32'h0000_000F};  // ori
    tbl[1] = '{32'h8C20_8000, 6'h23, 1'b1, 32'hFFFF_8000};  // lw
    tbl[2] = '{32'h3000_8000, 6'h0C, 1'b0, 32'h0000_8000};  // andi
    tbl[3] = '{32'h0000_8020, 6'h00, 1'b0, 32'h0000_8020};  // R-type
    tbl[4] = '{32'h1000_FFFE, 6'h04, 1'b1, 32'hFFFF_FFFE};  // beq
    exp_pc = 32'h0000_0104;
    for (int i = 0; i < 5; i++) begin
      imem_ready = 1'b1; imem_rdata = tbl[i].word;
      step();
      imem_ready = 1'b0;
      vectors++; if (valid !== 1'b1 || instr !== tbl[i].word) begin miscompares++; $display("FAIL dec%0d_ir got %b/%h want 1/%h", i, valid, instr, tbl[i].word); end
      vectors++; if (pc_out !== exp_pc) begin miscompares++; $display("FAIL dec%0d_pc_out got %h want %h", i, pc_out, exp_pc); end
      vectors++; if (opcode !== tbl[i].op || seu_en !== tbl[i].sel) begin miscompares++; $display("FAIL dec%0d_op got %h/%b want %h/%b", i, opcode, seu_en, tbl[i].op, tbl[i].sel); end
      vectors++; if (seu_ext(inm, seu_en) !== tbl[i].ext) begin miscompares++; $display("FAIL dec%0d_inm_ext got %h want %h", i, seu_ext(inm, seu_en), tbl[i].ext); end
      step();
      exp_pc = exp_pc + 32'd4;
      vectors++; if (imem_addr !== exp_pc || imem_req !== 1'b1) begin miscompares++; $display("FAIL dec%0d_next got %h/%b want %h/1", i, imem_addr, imem_req, exp_pc); end
    end
  endtask

  task automatic test_stall();
    // FETCH at 0x118
    imem_ready = 1'b1; imem_rdata = 32'h2108_0001;
    step();
    imem_ready = 1'b0; stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++; if (valid !== 1'b1 || instr !== 32'h2108_0001 || pc_out !== 32'h0000_0118 || imem_req !== 1'b0) begin
        miscompares++; $display("FAIL stall%0d got v=%b ir=%h pc=%h req=%b want 1/21080001/118/0", i, valid, instr, pc_out, imem_req);
      end
    end
    stall = 1'b0;
    step();
    vectors++; if (imem_addr !== 32'h0000_011C || imem_req !== 1'b1 || valid !== 1'b0) begin miscompares++; $display("FAIL stall_release got %h/%b/%b want 11c/1/0", imem_addr, imem_req, valid); end
  endtask

  task automatic test_ready_low();
    imem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h0000_011C || valid !== 1'b0) begin
        miscompares++; $display("FAIL wait%0d got req=%b addr=%h v=%b want 1/11c/0", i, imem_req, imem_addr, valid);
      end
    end
    imem_ready = 1'b1; imem_rdata = 32'hAC00_0004;
    step();
    imem_ready = 1'b0;
    vectors++; if (valid !== 1'b1 || pc_out !== 32'h0000_011C || seu_en !== 1'b1) begin miscompares++; $display("FAIL wait_done got v=%b pc=%h seu=%b want 1/11c/1", valid, pc_out, seu_en); end
    step();
    vectors++; if (imem_addr !== 32'h0000_0120) begin miscompares++; $display("FAIL wait_next got %h want 120", imem_addr); end
  endtask

  task automatic test_branch();
    imem_ready = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    branch_taken = 1'b1; branch_target = 32'h0000_2003;
    step();
    branch_taken = 1'b0; imem_ready = 1'b0;
    vectors++; if (valid !== 1'b0 || instr !== 32'hAC00_0004) begin miscompares++; $display("FAIL br_drop got v=%b ir=%h want 0/ac000004", valid, instr); end
    vectors++; if (imem_addr !== 32'h0000_2000 || imem_req !== 1'b1) begin miscompares++; $display("FAIL br_addr got %h/%b want 2000/1", imem_addr, imem_req); end
    // Redirect while stalled in ISSUE
    imem_ready = 1'b1; imem_rdata = 32'h3408_1234;
    step();
    imem_ready = 1'b0;
    vectors++; if (valid !== 1'b1 || pc_out !== 32'h0000_2000) begin miscompares++; $display("FAIL br_fetch got v=%b pc=%h want 1/2000", valid, pc_out); end
    stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h0000_3001;
    step();
    stall = 1'b0; branch_taken = 1'b0;
    vectors++; if (valid !== 1'b0 || imem_addr !== 32'h0000_3000 || instr !== 32'h3408_1234) begin
      miscompares++; $display("FAIL br_stall got v=%b addr=%h ir=%h want 0/3000/34081234", valid, imem_addr, instr);
    end
  endtask

  task automatic test_wrap();
    branch_taken = 1'b1; branch_target = 32'hFFFF_FFFF;
    step();
    branch_taken = 1'b0;
    vectors++; if (imem_addr !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL wrap_start got %h want fffffffc", imem_addr); end
    imem_ready = 1'b1; imem_rdata = 32'h2008_0001;
    step();
    imem_ready = 1'b0;
    vectors++; if (valid !== 1'b1 || pc_out !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL wrap_issue got v=%b pc=%h want 1/fffffffc", valid, pc_out); end
    step();
    vectors++; if (imem_addr !== 32'h0000_0000 || imem_req !== 1'b1) begin miscompares++; $display("FAIL wrap_next got %h/%b want 0/1", imem_addr, imem_req); end
  endtask

  task automatic test_reset_mid();
    imem_ready = 1'b1; imem_rdata = 32'h2008_0002;
    step();
    imem_ready = 1'b0;
    step();
    vectors++; if (imem_addr !== 32'h0000_0004 || imem_req !== 1'b1) begin miscompares++; $display("FAIL mid_pre got %h/%b want 4/1", imem_addr, imem_req); end
    #2 rst = 1'b1;
    #1;
    vectors++; if (imem_addr !== 32'h0000_0100 || imem_req !== 1'b1) begin miscompares++; $display("FAIL mid_rst_addr got %h/%b want 100/1", imem_addr, imem_req); end
    vectors++; if (valid !== 1'b0 || instr !== 32'h0 || pc_out !== 32'h0) begin miscompares++; $display("FAIL mid_rst_state got v=%b ir=%h pc=%h want 0/0/0", valid, instr, pc_out); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_decode();
    test_stall();
    test_ready_low();
    test_branch();
    test_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the processor. It holds the PC, fetches 32-bit instruction words from instruction memory over a req/ready handshake, and latches them into the instruction register (IR). From the IR it decodes the 16-bit immediate field and the sign/zero-extension select that feed the sign-extension unit (`inm`, `seu_en`) directly downstream. It also supplies opcode and register fields to the decoder.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value after reset.
- `clk`  in  1: single clock. All state updates on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `imem_req`  out  1: fetch request, level; held until `imem_ready`.
- `imem_addr`  out  32: fetch address, equal to the PC.
- `imem_ready`  in  1: `imem_rdata` is valid this cycle; the request completes.
- `imem_rdata`  in  32: instruction word.
- `stall`  in  1: downstream cannot consume the current instruction.
- `branch_taken`  in  1: single-cycle redirect pulse.
- `branch_target`  in  32: new PC, sampled when `branch_taken`=1.
- `valid`  out  1: the IR holds an instruction to be consumed.
- `instr`  out  32: IR contents.
- `pc_out`  out  32: address of the instruction in the IR.
- `opcode`  out  6: IR[31:26].
- `rs`  out  5: IR[25:21].
- `rt`  out  5: IR[20:16].
- `inm`  out  16: IR[15:0], to SEU `inm`.
- `seu_en`  out  1: to SEU `seu_en`. 1 selects sign extension, 0 selects zero extension.

## Operation
- The FSM has two states, encoded in one bit.
  - FETCH: `imem_req`=1 and `valid`=0.
  - ISSUE: `imem_req`=0 and `valid`=1.
- FETCH transitions:
  - If `imem_ready`=1 and `branch_taken`=0: IR←`imem_rdata`, `pc_out`←PC, PC←PC+4, go to ISSUE.
  - If `imem_ready`=0: stay in FETCH with the address held.
- ISSUE transitions:
  - If `stall`=1: stay, with IR, `pc_out` and `valid` held.
  - If `stall`=0: the instruction is consumed this cycle; go to FETCH.
- `branch_taken`=1 in any state has priority over everything else:
  - PC←`branch_target`, next state FETCH, `valid`=0 next cycle.
  - Any same-cycle `imem_rdata` is discarded and the IR is not written.
  - The redirect applies even when `stall`=1.
- Address width rules:
  - PC arithmetic is modulo 2^32. 32'hFFFF_FFFC+4 wraps to 32'h0000_0000.
  - PC[1:0] is forced to 0: `branch_target`[1:0] is ignored.
- `seu_en` decode, combinational from IR[31:26]:
  - 1 for 0x04 beq, 0x05 bne, 0x08 addi, 0x0A slti, 0x23 lw, 0x2B sw.
  - 0 for all other opcodes, including 0x0C andi, 0x0D ori, 0x0E xori, and 0x00 R-type.
- `inm`, `opcode`, `rs`, `rt`, `seu_en` are pure functions of the IR. They are meaningful only while `valid`=1 but are always driven.
- Reset values:
  - State FETCH, PC=`RESET_PC`.
  - IR=0, so `inm`=0, `seu_en`=0 and `opcode`=0.
  - `pc_out`=0, `valid`=0.
  - `imem_req` is asserted combinationally from the FETCH state while `rst` is high.
- Reset mid-fetch abandons the request. The memory must tolerate `imem_addr` changing while `imem_req` is held, because the request carries no outstanding-transaction state.

## Timing
- Fetch latency: with `imem_ready` high in the first FETCH cycle, `valid` rises on the next edge.
- Steady-state throughput is one instruction per 2 cycles: FETCH, then ISSUE.
- `imem_addr` and `imem_req` change only on clock edges, or asynchronously on `rst`.
- Redirect penalty: `branch_taken` at edge N puts `imem_addr`=`branch_target` in cycle N+1.
- `seu_en` and `inm` settle in the same cycle the IR updates. The combined SEU output `inm_ext` is valid in that cycle, with no extra register stage.

## Structure
- Shared package `proc_pkg` holds:
  - Opcode constants (`OP_RTYPE`, `OP_BEQ`, `OP_BNE`, `OP_ADDI`, `OP_SLTI`, `OP_ANDI`, `OP_ORI`, `OP_XORI`, `OP_LW`, `OP_SW`).
  - Field bit positions.
  - The FETCH/ISSUE state encoding.
- One sub-module, `imm_decode`: combinational, takes the IR and produces `opcode`, `rs`, `rt`, `inm`, `seu_en`. It is reused by later decode work.

## Test plan
- Reset with `RESET_PC`=32'h0000_0100, then release with `imem_ready`=1 and rdata=32'h2008_FFFF (addi, imm 0xFFFF) → `imem_addr`=0x100 and `imem_req`=1 during reset; after the edge, `valid`=1, `pc_out`=0x100, `inm`=16'hFFFF, `seu_en`=1, `opcode`=0x08; next fetch address is 0x104.
- ori 32'h3408_000F → `seu_en`=0, `inm`=16'h000F; SEU output `inm_ext`=32'h0000_000F.
- Hold `stall`=1 for 3 cycles in ISSUE → `valid`, `instr` and `pc_out` are constant and `imem_req`=0; after `stall` drops, FETCH resumes at PC+4.
- `imem_ready` held low for 5 cycles → `imem_req`=1 with a stable address throughout; `valid` rises exactly one edge after `imem_ready`.
- `branch_taken`=1 with `branch_target`=32'h0000_2003 in the same cycle as `imem_ready` → IR is unchanged, `valid`=0, next `imem_addr`=32'h0000_2000.
- PC=32'hFFFF_FFFC fetch completes → next `imem_addr`=32'h0000_0000. Separately, assert `rst` mid-FETCH → `imem_addr`=`RESET_PC` immediately, without waiting for a clock edge.
